// File: rtl/mips_pkg.sv
// Shared MIPS definitions: word width, reset/bubble constants, fetch-side types.
package mips_pkg;
  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC_DEF = 32'h0000_0000;
  localparam word_t NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {ST_RESET, ST_FIRST, ST_RUN} fetch_state_e;
  typedef enum logic [1:0] {IFID_LOAD, IFID_HOLD, IFID_FLUSH} ifid_op_e;

  typedef struct packed {
    word_t inst;
    word_t pc_plus4;
    logic  valid;
  } ifid_t;

  function automatic word_t word_align(input word_t a);
    return a & ~word_t'(3);
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched slot, hold it, or replace it with a bubble.
module if_id_reg
  import mips_pkg::*;
#(
  parameter word_t NOP_INST = NOP_INST_DEF
) (
  input  logic     clk,
  input  logic     reset,
  input  ifid_op_e op,
  input  ifid_t    d,
  output ifid_t    q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '{inst: NOP_INST, pc_plus4: '0, valid: 1'b0};
    end else begin
      case (op)
        IFID_LOAD:  q <= d;
        IFID_HOLD:  q <= q;
        IFID_FLUSH: q <= '{inst: NOP_INST, pc_plus4: '0, valid: 1'b0};
        default:    q <= '{inst: NOP_INST, pc_plus4: '0, valid: 1'b0};
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction fetch: PC register, redirect/stall mux, start-up FSM, IF/ID register.
module if_stage
  import mips_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEF,
  parameter word_t NOP_INST = NOP_INST_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             jump,
  input  logic [XLEN-1:0]  jump_target,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_inst,
  output logic [XLEN-1:0]  if_id_inst,
  output logic [XLEN-1:0]  if_id_pc_plus4,
  output logic             if_id_valid
);

  fetch_state_e state, state_nxt;
  word_t        pc, pc_nxt, pc_plus4;
  ifid_op_e     ifid_op;
  ifid_t        ifid_d, ifid_q;

  assign pc_plus4  = pc + word_t'(4);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = ST_FIRST;
      ST_FIRST: state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_RESET;
    endcase
  end

  // Until RUN the pipe is empty: PC parks at RESET_PC and IF/ID keeps a bubble.
  always_comb begin
    pc_nxt  = pc;
    ifid_op = IFID_FLUSH;
    if (state == ST_RUN) begin
      if (branch_taken) begin
        pc_nxt  = word_align(branch_target);
        ifid_op = IFID_FLUSH;
      end else if (jump) begin
        pc_nxt  = word_align(jump_target);
        ifid_op = IFID_FLUSH;
      end else if (stall) begin
        pc_nxt  = pc;
        ifid_op = IFID_HOLD;
      end else begin
        pc_nxt  = pc_plus4;
        ifid_op = IFID_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= pc_nxt;
  end

  assign ifid_d = '{inst: imem_inst, pc_plus4: pc_plus4, valid: 1'b1};

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .op    (ifid_op),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign if_id_inst     = ifid_q.inst;
  assign if_id_pc_plus4 = ifid_q.pc_plus4;
  assign if_id_valid    = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: driver queues expected post-edge state, monitor compares.
module tb_if_stage;
  import mips_pkg::*;

  localparam word_t NOP = 32'h0000_0000;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  logic  stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  word_t branch_target = '0, jump_target = '0;
  word_t imem_addr, imem_inst, if_id_inst, if_id_pc_plus4;
  logic  if_id_valid;

  typedef struct {
    word_t addr;
    word_t inst;
    word_t pc4;
    logic  valid;
    logic  chk_pc4;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_inst(imem_inst),
    .if_id_inst(if_id_inst), .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in: word content is a fixed function of the address.
  function automatic word_t mem(input word_t a);
    return a ^ 32'h2400_0000;
  endfunction
  assign imem_inst = mem(imem_addr);

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input word_t a, input word_t i, input word_t p,
                              input logic v, input logic c);
    exp_t e;
    e.addr = a; e.inst = i; e.pc4 = p; e.valid = v; e.chk_pc4 = c;
    return e;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      step_no++;
      check($sformatf("step%0d imem_addr", step_no), imem_addr, e.addr);
      check($sformatf("step%0d if_id_inst", step_no), if_id_inst, e.inst);
      check($sformatf("step%0d if_id_valid", step_no), word_t'(if_id_valid), word_t'(e.valid));
      if (e.chk_pc4)
        check($sformatf("step%0d if_id_pc_plus4", step_no), if_id_pc_plus4, e.pc4);
    end
  end

  task automatic drive(input logic st, input logic br, input word_t bt,
                       input logic jp, input word_t jt);
    stall = st; branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
  endtask

  task automatic step(input exp_t e);
    @(posedge clk);
    #1 q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " imem_addr"}, imem_addr, 32'h0);
    check({tag, " if_id_inst"}, if_id_inst, NOP);
    check({tag, " if_id_pc_plus4"}, if_id_pc_plus4, 32'h0);
    check({tag, " if_id_valid"}, word_t'(if_id_valid), 32'h0);
  endtask

  initial begin
    #12 check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    step(mk(32'h0, NOP, 32'h0, 0, 1));            // RESET -> FIRST
    step(mk(32'h0, NOP, 32'h0, 0, 1));            // FIRST -> RUN
    step(mk(32'h4, mem(32'h0), 32'h4, 1, 1));
    step(mk(32'h8, mem(32'h4), 32'h8, 1, 1));
    drive(0, 0, 0, 1, 32'h0C);
    step(mk(32'h0C, NOP, 32'h0, 0, 0));
    drive(0, 0, 0, 0, 0);
    step(mk(32'h10, mem(32'h0C), 32'h10, 1, 1));
    drive(1, 0, 0, 0, 0);
    step(mk(32'h10, mem(32'h0C), 32'h10, 1, 1));
    step(mk(32'h10, mem(32'h0C), 32'h10, 1, 1));
    drive(0, 0, 0, 0, 0);
    step(mk(32'h14, mem(32'h10), 32'h14, 1, 1));
    step(mk(32'h18, mem(32'h14), 32'h18, 1, 1));
    drive(0, 1, 32'h40, 0, 0);
    step(mk(32'h40, NOP, 32'h0, 0, 1));
    drive(0, 0, 0, 0, 0);
    step(mk(32'h44, mem(32'h40), 32'h44, 1, 1));
    drive(1, 1, 32'h80, 1, 32'hC0);
    step(mk(32'h80, NOP, 32'h0, 0, 1));
    drive(0, 0, 0, 0, 0);
    step(mk(32'h84, mem(32'h80), 32'h84, 1, 1));
    drive(0, 0, 0, 1, 32'h103);                   // misaligned target truncates
    step(mk(32'h100, NOP, 32'h0, 0, 0));
    drive(0, 0, 0, 0, 0);
    step(mk(32'h104, mem(32'h100), 32'h104, 1, 1));
    drive(0, 0, 0, 1, 32'hFFFF_FFF8);
    step(mk(32'hFFFF_FFF8, NOP, 32'h0, 0, 0));
    drive(0, 0, 0, 0, 0);
    step(mk(32'hFFFF_FFFC, mem(32'hFFFF_FFF8), 32'hFFFF_FFFC, 1, 1));
    step(mk(32'h0, mem(32'hFFFF_FFFC), 32'h0, 1, 1));
    drive(1, 0, 0, 1, 32'h20);                    // jump beats stall
    step(mk(32'h20, NOP, 32'h0, 0, 0));
    drive(0, 0, 0, 0, 0);
    step(mk(32'h24, mem(32'h20), 32'h24, 1, 1));

    // Reset mid-branch at PC=0x24: outputs must drop with no clock edge.
    drive(0, 1, 32'h60, 0, 0);
    #2 reset = 1'b0;
    #1 check_reset_vals("async reset");
    @(posedge clk);
    #1 check_reset_vals("reset held");
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    step(mk(32'h0, NOP, 32'h0, 0, 1));
    step(mk(32'h0, NOP, 32'h0, 0, 1));
    step(mk(32'h4, mem(32'h0), 32'h4, 1, 1));

    repeat (2) @(negedge clk);
    check("scoreboard drained", word_t'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
